// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM and its clear engine.
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sweep_state_t;

    // Words are merged byte by byte so the function stays width-independent.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_init_sweeper.sv
// Clear engine: walks every word once, one per cycle, while the ports are stalled.
// ST_IDLE | ports own the memory ; ST_SWEEP | writing INIT_VALUE to o_waddr
module ram_init_sweeper
    import ram_pkg::*;
#(
    parameter int AWIDTH        = 14,
    parameter int DEPTH         = 1 << AWIDTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_req,
    output logic              o_busy,
    output logic [AWIDTH-1:0] o_waddr,
    output logic              o_wen
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    sweep_state_t      r_state;
    logic [AWIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INIT_ON_RESET ? ST_SWEEP : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_init_req) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + AWIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = (r_state == ST_SWEEP);
    assign o_wen   = o_busy;
    assign o_waddr = r_cnt;

endmodule

// File: rtl/ram_dp_wbe_init.sv
// Dual-port byte-enable RAM with selectable read latency, read-during-write mode,
// port-0-priority collision merge and a clear engine sharing port 0's write path.
module ram_dp_wbe_init
    import ram_pkg::*;
#(
    parameter int                DWIDTH        = 32,
    parameter int                AWIDTH        = 14,
    parameter int                DEPTH         = 1 << AWIDTH,
    parameter int                READ_LATENCY  = 0,
    parameter int                RDW_MODE      = RDW_WRITE_FIRST,
    parameter logic [DWIDTH-1:0] INIT_VALUE    = '0,
    parameter bit                INIT_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_req,
    output logic                init_busy,
    input  logic                en0,
    input  logic                wen0,
    input  logic [DWIDTH/8-1:0] wbe0,
    input  logic [AWIDTH-1:0]   addr0,
    input  logic [DWIDTH-1:0]   d0,
    output logic [DWIDTH-1:0]   q0,
    output logic                rvalid0,
    output logic                rdy0,
    input  logic                en1,
    input  logic                wen1,
    input  logic [DWIDTH/8-1:0] wbe1,
    input  logic [AWIDTH-1:0]   addr1,
    input  logic [DWIDTH-1:0]   d1,
    output logic [DWIDTH-1:0]   q1,
    output logic                rvalid1,
    output logic                rdy1,
    output logic                collision
);

    localparam int NB = DWIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic              r_coll;

    logic              w_busy, w_swp_wen;
    logic [IW-1:0]     w_swp_addr;
    logic              w_inr0, w_inr1, w_acc0, w_acc1, w_wr0, w_wr1, w_coll;
    logic [DWIDTH-1:0] w_old0, w_old1, w_base0, w_fin0, w_fin1, w_wd0;
    logic [IW-1:0]     w_wa0;
    logic              w_we0, w_we1;

    ram_init_sweeper #(
        .AWIDTH        (IW),
        .DEPTH         (DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_sweeper (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_init_req (init_req),
        .o_busy     (w_busy),
        .o_waddr    (w_swp_addr),
        .o_wen      (w_swp_wen)
    );

    assign init_busy = w_busy;
    assign rdy0      = !w_busy;
    assign rdy1      = !w_busy;

    assign w_inr0 = ({1'b0, addr0} < (AWIDTH+1)'(DEPTH));
    assign w_inr1 = ({1'b0, addr1} < (AWIDTH+1)'(DEPTH));
    assign w_acc0 = en0 & rdy0 & !rst;
    assign w_acc1 = en1 & rdy1 & !rst;
    assign w_wr0  = w_acc0 & wen0 & w_inr0;
    assign w_wr1  = w_acc1 & wen1 & w_inr1;
    assign w_coll = w_wr0 & w_wr1 & (addr0 == addr1);
    assign w_old0 = w_inr0 ? r_mem[addr0[IW-1:0]] : '0;
    assign w_old1 = w_inr1 ? r_mem[addr1[IW-1:0]] : '0;

    // On a collision both ports resolve to the same final word: port 1's bytes first, port 0 on top.
    always_comb begin
        w_base0 = w_old0;
        w_fin0  = '0;
        w_fin1  = '0;
        for (int i = 0; i < NB; i++) begin
            if (w_coll)
                w_base0[8*i +: 8] = byte_merge(w_old0[8*i +: 8], d1[8*i +: 8], wbe1[i]);
        end
        for (int i = 0; i < NB; i++) begin
            w_fin0[8*i +: 8] = byte_merge(w_base0[8*i +: 8], d0[8*i +: 8], wbe0[i]);
            w_fin1[8*i +: 8] = byte_merge(w_old1[8*i +: 8],  d1[8*i +: 8], wbe1[i]);
        end
        if (w_coll)
            w_fin1 = w_fin0;
    end

    assign w_we0 = !rst & (w_swp_wen | w_wr0);
    assign w_wa0 = w_swp_wen ? w_swp_addr : addr0[IW-1:0];
    assign w_wd0 = w_swp_wen ? INIT_VALUE : w_fin0;
    assign w_we1 = w_wr1;

    always_ff @(posedge clk) begin
        if (w_we1)
            r_mem[addr1[IW-1:0]] <= w_fin1;
        if (w_we0)
            r_mem[w_wa0] <= w_wd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_coll <= 1'b0;
        else
            r_coll <= w_coll;
    end
    assign collision = r_coll;

    generate
        if (READ_LATENCY == 0) begin : g_async
            assign q0      = w_old0;
            assign q1      = w_old1;
            assign rvalid0 = w_acc0;
            assign rvalid1 = w_acc1;
        end else begin : g_reg
            logic [DWIDTH-1:0] r_q0, r_q1, w_rd0, w_rd1;
            logic              r_rv0, r_rv1;

            // Write-first returns the word memory holds after this edge, collisions included.
            assign w_rd0 = (wen0 && RDW_MODE == RDW_WRITE_FIRST) ? (w_inr0 ? w_fin0 : '0) : w_old0;
            assign w_rd1 = (wen1 && RDW_MODE == RDW_WRITE_FIRST) ? (w_inr1 ? w_fin1 : '0) : w_old1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q0  <= '0;
                    r_q1  <= '0;
                    r_rv0 <= 1'b0;
                    r_rv1 <= 1'b0;
                end else begin
                    r_rv0 <= w_acc0;
                    r_rv1 <= w_acc1;
                    if (w_acc0)
                        r_q0 <= w_rd0;
                    if (w_acc1)
                        r_q1 <= w_rd1;
                end
            end

            assign q0      = r_q0;
            assign q1      = r_q1;
            assign rvalid0 = r_rv0;
            assign rvalid1 = r_rv1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_wbe_init.sv
// Scoreboard bench: three DUT flavours (async read, registered write-first, registered
// read-first) share one stimulus stream and one array-based memory model.
module tb_ram_dp_wbe_init;

    localparam int          DEPTH = 16;
    localparam int          NB    = 4;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;

    logic        clk = 1'b0, rst = 1'b1, init_req = 1'b0;
    logic        en0 = 1'b0, wen0 = 1'b0, en1 = 1'b0, wen1 = 1'b0;
    logic [3:0]  wbe0 = '0, wbe1 = '0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [31:0] d0 = '0, d1 = '0;

    logic [31:0] q0_o [3], q1_o [3];
    logic        rv0_o [3], rv1_o [3], rdy0_o [3], rdy1_o [3], busy_o [3], coll_o [3];

    always #5 clk = ~clk;

    ram_dp_wbe_init #(.DWIDTH(32), .AWIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(0), .RDW_MODE(0),
                      .INIT_VALUE(INIT), .INIT_ON_RESET(1'b1)) u_l0 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy_o[0]),
        .en0(en0), .wen0(wen0), .wbe0(wbe0), .addr0(addr0), .d0(d0), .q0(q0_o[0]), .rvalid0(rv0_o[0]), .rdy0(rdy0_o[0]),
        .en1(en1), .wen1(wen1), .wbe1(wbe1), .addr1(addr1), .d1(d1), .q1(q1_o[0]), .rvalid1(rv1_o[0]), .rdy1(rdy1_o[0]),
        .collision(coll_o[0]));

    ram_dp_wbe_init #(.DWIDTH(32), .AWIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(0),
                      .INIT_VALUE(INIT), .INIT_ON_RESET(1'b1)) u_wf (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy_o[1]),
        .en0(en0), .wen0(wen0), .wbe0(wbe0), .addr0(addr0), .d0(d0), .q0(q0_o[1]), .rvalid0(rv0_o[1]), .rdy0(rdy0_o[1]),
        .en1(en1), .wen1(wen1), .wbe1(wbe1), .addr1(addr1), .d1(d1), .q1(q1_o[1]), .rvalid1(rv1_o[1]), .rdy1(rdy1_o[1]),
        .collision(coll_o[1]));

    ram_dp_wbe_init #(.DWIDTH(32), .AWIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(1),
                      .INIT_VALUE(INIT), .INIT_ON_RESET(1'b1)) u_rf (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy_o[2]),
        .en0(en0), .wen0(wen0), .wbe0(wbe0), .addr0(addr0), .d0(d0), .q0(q0_o[2]), .rvalid0(rv0_o[2]), .rdy0(rdy0_o[2]),
        .en1(en1), .wen1(wen1), .wbe1(wbe1), .addr1(addr1), .d1(d1), .q1(q1_o[2]), .rvalid1(rv1_o[2]), .rdy1(rdy1_o[2]),
        .collision(coll_o[2]));

    typedef struct packed {
        logic            busy;
        logic [1:0]      v;
        logic [1:0][31:0] d;
    } comb_exp_t;

    typedef struct packed {
        logic            coll;
        logic [1:0]      v;
        logic [1:0][31:0] dwf;
        logic [1:0][31:0] drf;
    } reg_exp_t;

    comb_exp_t   qc [$];
    reg_exp_t    qr [$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] lq_wf [2], lq_rf [2];
    int          swp_left = 0, swp_addr = 0;
    int          checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Combinational outputs (busy, rdy, async-read port) checked mid-cycle.
    always @(negedge clk) begin
        comb_exp_t ce;
        if (qc.size() > 0) begin
            ce = qc.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("init_busy[%0d]", i), 32'(busy_o[i]), 32'(ce.busy));
                chk($sformatf("rdy0[%0d]", i), 32'(rdy0_o[i]), 32'(!ce.busy));
                chk($sformatf("rdy1[%0d]", i), 32'(rdy1_o[i]), 32'(!ce.busy));
            end
            chk("l0 rvalid0", 32'(rv0_o[0]), 32'(ce.v[0]));
            chk("l0 rvalid1", 32'(rv1_o[0]), 32'(ce.v[1]));
            if (ce.v[0]) chk("l0 q0", q0_o[0], ce.d[0]);
            if (ce.v[1]) chk("l0 q1", q1_o[0], ce.d[1]);
        end
    end

    // Registered outputs checked just after the edge that produced them.
    always @(posedge clk) begin
        reg_exp_t re;
        #1;
        if (qr.size() > 0) begin
            re = qr.pop_front();
            for (int i = 0; i < 3; i++)
                chk($sformatf("collision[%0d]", i), 32'(coll_o[i]), 32'(re.coll));
            chk("wf rvalid0", 32'(rv0_o[1]), 32'(re.v[0]));
            chk("wf rvalid1", 32'(rv1_o[1]), 32'(re.v[1]));
            chk("wf q0", q0_o[1], re.dwf[0]);
            chk("wf q1", q1_o[1], re.dwf[1]);
            chk("rf rvalid0", 32'(rv0_o[2]), 32'(re.v[0]));
            chk("rf rvalid1", 32'(rv1_o[2]), 32'(re.v[1]));
            chk("rf q0", q0_o[2], re.drf[0]);
            chk("rf q1", q1_o[2], re.drf[1]);
        end
    end

    // One clock of stimulus; the model predicts every output this cycle produces.
    task automatic cyc(input bit r, input bit ireq, input bit [1:0] e, input bit [1:0] w,
                       input logic [1:0][3:0] b, input logic [1:0][4:0] a, input logic [1:0][31:0] d);
        comb_exp_t   ce;
        reg_exp_t    re;
        logic [31:0] nm [DEPTH];
        logic [31:0] oldw [2];
        bit [1:0]    acc;
        bit          busy, coll;
        @(posedge clk);
        #2;
        rst = r; init_req = ireq;
        en0 = e[0]; wen0 = w[0]; wbe0 = b[0]; addr0 = a[0]; d0 = d[0];
        en1 = e[1]; wen1 = w[1]; wbe1 = b[1]; addr1 = a[1]; d1 = d[1];
        ce = '0;
        re = '0;
        if (r) begin
            swp_left = DEPTH;
            swp_addr = 0;
            for (int p = 0; p < 2; p++) begin
                lq_wf[p] = '0;
                lq_rf[p] = '0;
            end
            ce.busy = 1'b1;
        end else begin
            busy = (swp_left > 0);
            nm   = mem_m;
            for (int p = 0; p < 2; p++) begin
                acc[p]  = e[p] && !busy;
                oldw[p] = (a[p] < DEPTH) ? mem_m[a[p][3:0]] : 32'h0;
            end
            for (int p = 1; p >= 0; p--)
                if (acc[p] && w[p] && a[p] < DEPTH)
                    for (int i = 0; i < NB; i++)
                        if (b[p][i]) nm[a[p][3:0]][8*i +: 8] = d[p][8*i +: 8];
            coll = acc[0] && acc[1] && w[0] && w[1] && (a[0] == a[1]) && (a[0] < DEPTH);
            for (int p = 0; p < 2; p++)
                if (acc[p]) begin
                    lq_rf[p] = oldw[p];
                    lq_wf[p] = w[p] ? ((a[p] < DEPTH) ? nm[a[p][3:0]] : 32'h0) : oldw[p];
                end
            ce.busy = busy;
            ce.v    = acc;
            ce.d[0] = oldw[0];
            ce.d[1] = oldw[1];
            re.coll = coll;
            re.v    = acc;
            for (int p = 0; p < 2; p++) begin
                re.dwf[p] = lq_wf[p];
                re.drf[p] = lq_rf[p];
            end
            mem_m = nm;
            if (busy) begin
                mem_m[swp_addr] = INIT;
                swp_addr++;
                swp_left--;
            end else if (ireq) begin
                swp_left = DEPTH;
                swp_addr = 0;
            end
        end
        qc.push_back(ce);
        qr.push_back(re);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic op(input int p, input bit wr, input logic [3:0] be, input logic [4:0] ad, input logic [31:0] dat);
        bit [1:0]         e = '0, w = '0;
        logic [1:0][3:0]  b = '0;
        logic [1:0][4:0]  a = '0;
        logic [1:0][31:0] d = '0;
        e[p] = 1'b1; w[p] = wr; b[p] = be; a[p] = ad; d[p] = dat;
        cyc(1'b0, 1'b0, e, w, b, a, d);
    endtask

    task automatic read_all();
        for (int k = 0; k < DEPTH; k++)
            cyc(1'b0, 1'b0, 2'b11, 2'b00, '0, {5'(DEPTH - 1 - k), 5'(k)}, '0);
    endtask

    initial begin
        bit [1:0]         e, w;
        logic [1:0][3:0]  b;
        logic [1:0][4:0]  a;
        logic [1:0][31:0] d;
        bit               ireq;

        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
        idle(5);
        op(1, 1'b1, 4'hF, 5'd2, 32'h12345678);
        idle(12);
        read_all();

        op(0, 1'b1, 4'b0101, 5'd5, 32'h11223344);
        op(0, 1'b0, 4'h0, 5'd5, 32'h0);
        op(1, 1'b0, 4'h0, 5'd5, 32'h0);

        op(0, 1'b1, 4'hF, 5'd7, 32'h0);
        cyc(1'b0, 1'b0, 2'b11, 2'b11, {4'b0110, 4'b0011}, {5'd7, 5'd7}, {32'hBBBBBBBB, 32'hAAAAAAAA});
        op(0, 1'b0, 4'h0, 5'd7, 32'h0);
        idle(1);

        op(0, 1'b1, 4'hF, 5'd3, 32'h0);
        op(0, 1'b1, 4'hF, 5'd3, 32'h55);
        op(1, 1'b0, 4'h0, 5'd3, 32'h0);
        cyc(1'b0, 1'b0, 2'b11, 2'b01, {4'h0, 4'hF}, {5'd9, 5'd9}, {32'h0, 32'hCAFEF00D});
        op(1, 1'b1, 4'h0, 5'd9, 32'hFFFFFFFF);

        op(0, 1'b1, 4'hF, 5'd18, 32'h87654321);
        op(1, 1'b0, 4'h0, 5'd18, 32'h0);
        op(0, 1'b0, 4'h0, 5'd31, 32'h0);

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                e[p] = ($urandom_range(0, 9) < 7);
                w[p] = 1'($urandom_range(0, 1));
                b[p] = 4'($urandom);
                a[p] = 5'($urandom_range(0, 19));
                d[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) a[1] = a[0];
            ireq = ($urandom_range(0, 79) == 0);
            cyc(1'b0, ireq, e, w, b, a, d);
        end
        idle(DEPTH + 1);

        for (int k = 0; k < DEPTH; k++) op(k % 2, 1'b1, 4'hF, 5'(k), $urandom);
        cyc(1'b0, 1'b1, 2'b01, 2'b01, {4'h0, 4'hF}, {5'd0, 5'd4}, {32'h0, 32'h0BADC0DE});
        for (int k = 0; k < 3; k++) op(1, 1'b1, 4'hF, 5'd6, 32'h66666666);
        cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
        cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
        idle(DEPTH + 2);
        read_all();

        @(posedge clk);
        #3;
        chk("scoreboard comb drained", 32'(qc.size()), 32'd0);
        chk("scoreboard reg drained", 32'(qr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
